// File: rtl/wb_i2c_pkg.sv
// Package for the Wishbone I2C command queue.
// Holds the register map, command word bit positions, STATUS bit positions,
// control bit positions and a helper that extracts a command word from a
// Wishbone write.
package wb_i2c_pkg;

  localparam int unsigned CMD_W         = 12;
  localparam int unsigned RX_W          = 8;

  // Command word layout: {nack_last, read, stop, start, byte[7:0]}
  localparam int unsigned CMD_BYTE_LSB  = 0;
  localparam int unsigned CMD_START     = 8;
  localparam int unsigned CMD_STOP      = 9;
  localparam int unsigned CMD_READ      = 10;
  localparam int unsigned CMD_NACK_LAST = 11;

  // STATUS register layout
  localparam int unsigned ST_CMDQ_FILL_LSB = 0;
  localparam int unsigned ST_RXQ_FILL_LSB  = 8;
  localparam int unsigned ST_CMDQ_FULL     = 16;
  localparam int unsigned ST_RXQ_EMPTY     = 17;
  localparam int unsigned ST_RX_OVF        = 18;
  localparam int unsigned ST_NACK          = 19;

  // RXQ read word: byte in [7:0] plus a valid marker bit
  localparam int unsigned RXQ_VALID_BIT = 8;

  // CTRL register layout
  localparam int unsigned CTRL_FLUSH = 0;
  localparam int unsigned CTRL_CLEAR = 1;

  typedef enum logic [1:0] {
    REG_CMDQ   = 2'd0,
    REG_RXQ    = 2'd1,
    REG_STATUS = 2'd2,
    REG_CTRL   = 2'd3
  } wb_reg_e;

  function automatic logic [CMD_W-1:0] cmd_pack(input logic [31:0] w);
    logic [CMD_W-1:0] c;
    c                      = '0;
    c[CMD_BYTE_LSB +: 8]   = w[CMD_BYTE_LSB +: 8];
    c[CMD_START]           = w[CMD_START];
    c[CMD_STOP]            = w[CMD_STOP];
    c[CMD_READ]            = w[CMD_READ];
    c[CMD_NACK_LAST]       = w[CMD_NACK_LAST];
    return c;
  endfunction

endpackage

// File: rtl/wb_i2c_sfifo.sv
// Synchronous FIFO with registered valid and a fill count.
// Ports:
//   i_clk, i_reset  clock, asynchronous active-high reset
//   i_flush         empty the FIFO (wins over push/pop)
//   i_push, i_data  write side; push while full is ignored
//   i_pop           read side; pop while empty is ignored
//   o_data          head entry, 0 when empty
//   o_valid         FIFO non-empty (registered)
//   o_fill          entry count, LGFIFO+1 bits
//   o_full          fill equals depth
module wb_i2c_sfifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LGFIFO = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [WIDTH-1:0]  i_data,
  input  logic              i_pop,
  output logic [WIDTH-1:0]  o_data,
  output logic              o_valid,
  output logic [LGFIFO:0]   o_fill,
  output logic              o_full
);

  localparam int unsigned DEPTH = 1 << LGFIFO;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [LGFIFO-1:0] r_wr;
  logic [LGFIFO-1:0] r_rd;
  logic [LGFIFO:0]   r_fill;
  logic              r_valid;
  logic [LGFIFO:0]   w_fill_next;
  logic              w_full;
  logic              w_push;
  logic              w_pop;

  assign w_full = (r_fill == (LGFIFO+1)'(DEPTH));
  assign w_push = i_push & ~w_full & ~i_flush;
  assign w_pop  = i_pop & r_valid & ~i_flush;

  always_comb begin
    w_fill_next = r_fill;
    if (i_flush)
      w_fill_next = '0;
    else if (w_push && !w_pop)
      w_fill_next = r_fill + (LGFIFO+1)'(1);
    else if (w_pop && !w_push)
      w_fill_next = r_fill - (LGFIFO+1)'(1);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_fill  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_fill  <= w_fill_next;
      r_valid <= (w_fill_next != '0);
      if (i_flush) begin
        r_wr <= '0;
        r_rd <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + LGFIFO'(1);
        if (w_pop)  r_rd <= r_rd + LGFIFO'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  // Gate the head so the output reads 0 while empty (memory is not reset).
  assign o_data  = r_valid ? r_mem[r_rd] : '0;
  assign o_valid = r_valid;
  assign o_fill  = r_fill;
  assign o_full  = w_full;

endmodule

// File: rtl/wb_i2c_cmdq.sv
// Pipelined Wishbone slave: I2C command queue, receive queue, STATUS and CTRL.
// Ports:
//   i_clk, i_reset                 clock, asynchronous active-high reset
//   i_wb_cyc/stb/we/addr/data/sel  Wishbone request
//   o_wb_stall                     combinational, only for CMDQ write while full
//   o_wb_ack/o_wb_err/o_wb_data    registered response, 1 cycle after accept
//   o_cmd_valid/i_cmd_ready/o_cmd_data   command stream to the I2C bit engine
//   i_rsp_valid/i_rsp_data         received bytes (no backpressure)
//   i_nack                         slave NACK pulse
// Register map (word address): 0 CMDQ (W), 1 RXQ (R), 2 STATUS (R), 3 CTRL (W).
module wb_i2c_cmdq
  import wb_i2c_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 26,
  parameter int unsigned LGFIFO = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [AW-1:0]     i_wb_addr,
  input  logic [DW-1:0]     i_wb_data,
  input  logic [DW/8-1:0]   i_wb_sel,
  output logic              o_wb_stall,
  output logic              o_wb_ack,
  output logic              o_wb_err,
  output logic [DW-1:0]     o_wb_data,
  output logic              o_cmd_valid,
  input  logic              i_cmd_ready,
  output logic [CMD_W-1:0]  o_cmd_data,
  input  logic              i_rsp_valid,
  input  logic [RX_W-1:0]   i_rsp_data,
  input  logic              i_nack
);

  wb_reg_e          w_reg;
  logic             w_addr_ok;
  logic             w_stall;
  logic             w_acc;
  logic             w_ok;
  logic             w_cq_push;
  logic             w_rq_pop;
  logic             w_flush;
  logic             w_clear;
  logic [DW-1:0]    w_rdata;
  logic [DW-1:0]    w_status;

  logic             w_cq_valid;
  logic             w_cq_full;
  logic [LGFIFO:0]  w_cq_fill;
  logic [CMD_W-1:0] w_cq_data;
  logic             w_rq_valid;
  logic             w_rq_full;
  logic [LGFIFO:0]  w_rq_fill;
  logic [RX_W-1:0]  w_rq_data;

  logic             r_ack;
  logic             r_err;
  logic [DW-1:0]    r_data;
  logic             r_rx_ovf;
  logic             r_nack;

  logic             w_unused;
  assign w_unused = ^{i_wb_data[DW-1:CMD_W], i_wb_sel[DW/8-1:2]};

  assign w_addr_ok = (i_wb_addr[AW-1:2] == '0);
  assign w_reg     = wb_reg_e'(i_wb_addr[1:0]);
  assign w_stall   = i_wb_stb & i_wb_we & w_addr_ok & (w_reg == REG_CMDQ) & w_cq_full;
  assign w_acc     = i_wb_cyc & i_wb_stb & ~w_stall;

  always_comb begin
    w_status                                 = '0;
    w_status[ST_CMDQ_FILL_LSB +: LGFIFO+1]   = w_cq_fill;
    w_status[ST_RXQ_FILL_LSB +: LGFIFO+1]    = w_rq_fill;
    w_status[ST_CMDQ_FULL]                   = w_cq_full;
    w_status[ST_RXQ_EMPTY]                   = ~w_rq_valid;
    w_status[ST_RX_OVF]                      = r_rx_ovf;
    w_status[ST_NACK]                        = r_nack;
  end

  // Anything not matched below (bad upper address, wrong direction,
  // missing byte selects, empty RXQ) leaves w_ok low and answers with err.
  always_comb begin
    w_ok      = 1'b0;
    w_cq_push = 1'b0;
    w_rq_pop  = 1'b0;
    w_flush   = 1'b0;
    w_clear   = 1'b0;
    w_rdata   = '0;
    if (w_acc && w_addr_ok) begin
      case (w_reg)
        REG_CMDQ: begin
          if (i_wb_we && (i_wb_sel[1:0] == 2'b11)) begin
            w_ok      = 1'b1;
            w_cq_push = 1'b1;
          end
        end
        REG_RXQ: begin
          if (!i_wb_we && w_rq_valid) begin
            w_ok                   = 1'b1;
            w_rq_pop               = 1'b1;
            w_rdata[RX_W-1:0]      = w_rq_data;
            w_rdata[RXQ_VALID_BIT] = 1'b1;
          end
        end
        REG_STATUS: begin
          if (!i_wb_we) begin
            w_ok    = 1'b1;
            w_rdata = w_status;
          end
        end
        REG_CTRL: begin
          if (i_wb_we && i_wb_sel[0]) begin
            w_ok    = 1'b1;
            w_flush = i_wb_data[CTRL_FLUSH];
            w_clear = i_wb_data[CTRL_CLEAR];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_data   <= '0;
      r_rx_ovf <= 1'b0;
      r_nack   <= 1'b0;
    end else begin
      // w_acc already requires i_wb_cyc, so a dropped cycle clears the response.
      r_ack  <= w_acc & w_ok;
      r_err  <= w_acc & ~w_ok;
      r_data <= w_rdata;
      // Setting events win over a simultaneous clear.
      if (i_nack)
        r_nack <= 1'b1;
      else if (w_clear)
        r_nack <= 1'b0;
      if (i_rsp_valid && w_rq_full && !w_flush)
        r_rx_ovf <= 1'b1;
      else if (w_clear)
        r_rx_ovf <= 1'b0;
    end
  end

  wb_i2c_sfifo #(
    .WIDTH  (CMD_W),
    .LGFIFO (LGFIFO)
  ) u_cmdq (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (w_flush),
    .i_push  (w_cq_push),
    .i_data  (cmd_pack(i_wb_data)),
    .i_pop   (i_cmd_ready),
    .o_data  (w_cq_data),
    .o_valid (w_cq_valid),
    .o_fill  (w_cq_fill),
    .o_full  (w_cq_full)
  );

  wb_i2c_sfifo #(
    .WIDTH  (RX_W),
    .LGFIFO (LGFIFO)
  ) u_rxq (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (w_flush),
    .i_push  (i_rsp_valid),
    .i_data  (i_rsp_data),
    .i_pop   (w_rq_pop),
    .o_data  (w_rq_data),
    .o_valid (w_rq_valid),
    .o_fill  (w_rq_fill),
    .o_full  (w_rq_full)
  );

  assign o_wb_stall  = w_stall;
  assign o_wb_ack    = r_ack;
  assign o_wb_err    = r_err;
  assign o_wb_data   = r_data;
  assign o_cmd_valid = w_cq_valid;
  assign o_cmd_data  = w_cq_data;

endmodule

// File: tb/tb_wb_i2c_cmdq.sv
module tb_wb_i2c_cmdq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [25:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  sel = '0;
  logic        cmd_ready = 1'b0, rsp_valid = 1'b0, nack = 1'b0;
  logic [7:0]  rsp_data = '0;
  logic        o_stall, o_ack, o_err, o_cmd_valid;
  logic [31:0] o_data;
  logic [11:0] o_cmd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_i2c_cmdq #(.DW(32), .AW(26), .LGFIFO(4)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_wb_cyc    (cyc),
    .i_wb_stb    (stb),
    .i_wb_we     (we),
    .i_wb_addr   (addr),
    .i_wb_data   (wdata),
    .i_wb_sel    (sel),
    .o_wb_stall  (o_stall),
    .o_wb_ack    (o_ack),
    .o_wb_err    (o_err),
    .o_wb_data   (o_data),
    .o_cmd_valid (o_cmd_valid),
    .i_cmd_ready (cmd_ready),
    .o_cmd_data  (o_cmd_data),
    .i_rsp_valid (rsp_valid),
    .i_rsp_data  (rsp_data),
    .i_nack      (nack)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural model: two queues and two flags, stepped once per clock edge.
  logic [11:0] cq[$];
  logic [7:0]  rq[$];
  logic        m_ovf = 1'b0, m_nack = 1'b0;
  logic        e_ack = 1'b0, e_err = 1'b0;
  logic [31:0] e_data = '0;
  logic [31:0] st, rd;
  logic        acc, ok, stall_pre, push_c, pop_r, flush, clr, fire;
  int          rq_n;

  always @(posedge clk) begin
    if (rst) begin
      cq.delete(); rq.delete();
      m_ovf = 1'b0; m_nack = 1'b0;
      e_ack = 1'b0; e_err = 1'b0; e_data = '0;
    end else begin
      st = 32'(cq.size()) | (32'(rq.size()) << 8);
      if (cq.size() == 16) st[16] = 1'b1;
      if (rq.size() == 0)  st[17] = 1'b1;
      st[18] = m_ovf;
      st[19] = m_nack;
      stall_pre = stb && we && (addr == 26'd0) && (cq.size() == 16);
      acc  = cyc && stb && !stall_pre;
      fire = cmd_ready && (cq.size() > 0);
      rq_n = rq.size();
      ok = 0; push_c = 0; pop_r = 0; flush = 0; clr = 0; rd = '0;
      if (acc) begin
        if (addr == 26'd0 && we && sel[1:0] == 2'b11) begin ok = 1; push_c = 1; end
        else if (addr == 26'd1 && !we && rq_n > 0)   begin ok = 1; pop_r = 1; end
        else if (addr == 26'd2 && !we)               begin ok = 1; rd = st; end
        else if (addr == 26'd3 && we && sel[0])      begin ok = 1; flush = wdata[0]; clr = wdata[1]; end
      end
      if (flush) begin
        cq.delete(); rq.delete();
      end else begin
        if (fire)   void'(cq.pop_front());
        if (push_c) cq.push_back(wdata[11:0]);
        if (pop_r)  rd = 32'h100 | 32'(rq.pop_front());
        if (rsp_valid && rq_n < 16) rq.push_back(rsp_data);
      end
      if (nack) m_nack = 1'b1;
      else if (clr) m_nack = 1'b0;
      if (rsp_valid && !flush && rq_n == 16) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      e_ack  = acc && ok;
      e_err  = acc && !ok;
      e_data = ok ? rd : '0;
    end
    #1;
    chk("stall", 32'(o_stall), 32'(stb && we && (addr == 26'd0) && (cq.size() == 16)));
    chk("ack", 32'(o_ack), 32'(e_ack));
    chk("err", 32'(o_err), 32'(e_err));
    chk("rdata", o_data, e_data);
    chk("cmd_valid", 32'(o_cmd_valid), 32'(cq.size() > 0));
    chk("cmd_data", 32'(o_cmd_data), (cq.size() > 0) ? 32'(cq[0]) : 32'd0);
  end

  task automatic wb_op(input logic w, input logic [25:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic nack_p, input logic rsp_p,
                       output logic ack_o, output logic err_o, output logic [31:0] data_o);
    int n;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; addr = a; wdata = d; sel = s;
    nack = nack_p; rsp_valid = rsp_p;
    #1;
    n = 0;
    while (o_stall && n < 64) begin
      @(negedge clk); #1; n++;
    end
    chk("op_stall_released", 32'(o_stall), 32'd0);
    @(posedge clk); #2;
    ack_o = o_ack; err_o = o_err; data_o = o_data;
    @(negedge clk);
    cyc = 0; stb = 0; we = 0; nack = 0; rsp_valid = 0;
  endtask

  logic        a, e;
  logic [31:0] d;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    chk("rst_ack", 32'(o_ack), 32'd0);
    chk("rst_cmd_valid", 32'(o_cmd_valid), 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);

    // 1: STATUS after reset
    wb_op(1'b0, 26'd2, 32'd0, 4'hF, 1'b0, 1'b0, a, e, d);
    chk("t1_ack", 32'(a), 32'd1);
    chk("t1_status", d, 32'h0002_0000);

    // 2: single command, then consume it
    wb_op(1'b1, 26'd0, 32'h1A5, 4'h3, 1'b0, 1'b0, a, e, d);
    chk("t2_ack", 32'(a), 32'd1);
    @(posedge clk); #2;
    chk("t2_cmd_valid", 32'(o_cmd_valid), 32'd1);
    chk("t2_cmd_data", 32'(o_cmd_data), 32'h1A5);
    @(negedge clk); cmd_ready = 1;
    @(posedge clk); #2;
    chk("t2_valid_drop", 32'(o_cmd_valid), 32'd0);
    @(negedge clk); cmd_ready = 0;

    // 3: fill the command queue, 17th write stalls until one pop
    for (int i = 0; i < 16; i++)
      wb_op(1'b1, 26'd0, 32'h100 + 32'(i), 4'h3, 1'b0, 1'b0, a, e, d);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; addr = 26'd0; wdata = 32'h0F0; sel = 4'h3;
    repeat (3) begin
      @(posedge clk); #2;
      chk("t3_stall_held", 32'(o_stall), 32'd1);
      chk("t3_no_ack", 32'(o_ack), 32'd0);
    end
    @(negedge clk); cmd_ready = 1;
    @(posedge clk); #2;
    chk("t3_stall_release", 32'(o_stall), 32'd0);
    @(negedge clk); cmd_ready = 0;
    @(posedge clk); #2;
    chk("t3_ack", 32'(o_ack), 32'd1);
    @(negedge clk); cyc = 0; stb = 0; we = 0;
    cmd_ready = 1;
    repeat (20) @(negedge clk);
    cmd_ready = 0;

    // 4: RXQ empty read, then a byte, then push+pop in the same cycle
    wb_op(1'b0, 26'd1, 32'd0, 4'hF, 1'b0, 1'b0, a, e, d);
    chk("t4_empty_err", 32'(e), 32'd1);
    chk("t4_empty_noack", 32'(a), 32'd0);
    @(negedge clk); rsp_valid = 1; rsp_data = 8'h3C;
    @(negedge clk); rsp_valid = 0;
    wb_op(1'b0, 26'd1, 32'd0, 4'hF, 1'b0, 1'b0, a, e, d);
    chk("t4_rx_data", d, 32'h0000_013C);
    @(negedge clk); rsp_valid = 1; rsp_data = 8'h11;
    @(negedge clk); rsp_valid = 0; rsp_data = 8'h22;
    wb_op(1'b0, 26'd1, 32'd0, 4'hF, 1'b0, 1'b1, a, e, d);
    chk("t4_pushpop_data", d, 32'h0000_0111);
    wb_op(1'b0, 26'd2, 32'd0, 4'hF, 1'b0, 1'b0, a, e, d);
    chk("t4_pushpop_fill", d, 32'h0000_0100);
    wb_op(1'b0, 26'd1, 32'd0, 4'hF, 1'b0, 1'b0, a, e, d);
    chk("t4_second_byte", d, 32'h0000_0122);

    // 5: RX overflow, nack sticky, flush/clear and their corner cases
    @(negedge clk); rsp_valid = 1;
    for (int i = 0; i < 17; i++) begin
      rsp_data = 8'(32'h40 + 32'(i));
      @(negedge clk);
    end
    rsp_valid = 0;
    nack = 1; @(negedge clk); nack = 0;
    wb_op(1'b0, 26'd2, 32'd0, 4'hF, 1'b0, 1'b0, a, e, d);
    chk("t5_status_ovf", d, 32'h000C_1000);
    wb_op(1'b1, 26'd3, 32'h3, 4'h1, 1'b0, 1'b0, a, e, d);
    chk("t5_ctrl_ack", 32'(a), 32'd1);
    wb_op(1'b0, 26'd2, 32'd0, 4'hF, 1'b0, 1'b0, a, e, d);
    chk("t5_status_cleared", d, 32'h0002_0000);
    wb_op(1'b1, 26'd3, 32'h3, 4'hE, 1'b0, 1'b0, a, e, d);
    chk("t5_ctrl_sel_err", 32'(e), 32'd1);
    wb_op(1'b1, 26'd0, 32'h0AB, 4'h1, 1'b0, 1'b0, a, e, d);
    chk("t5_cmdq_sel_err", 32'(e), 32'd1);
    wb_op(1'b1, 26'd3, 32'h2, 4'h1, 1'b1, 1'b0, a, e, d);
    wb_op(1'b0, 26'd2, 32'd0, 4'hF, 1'b0, 1'b0, a, e, d);
    chk("t5_nack_beats_clear", d, 32'h000A_0000);
    wb_op(1'b1, 26'd3, 32'h2, 4'h1, 1'b0, 1'b0, a, e, d);
    rsp_data = 8'h77;
    wb_op(1'b1, 26'd3, 32'h1, 4'h1, 1'b0, 1'b1, a, e, d);
    wb_op(1'b0, 26'd2, 32'd0, 4'hF, 1'b0, 1'b0, a, e, d);
    chk("t5_flush_drops_rsp", d, 32'h0002_0000);

    // 6: decode errors, then reset over a pending request
    wb_op(1'b1, 26'd4, 32'h1, 4'hF, 1'b0, 1'b0, a, e, d);
    chk("t6_addr4_err", 32'(e), 32'd1);
    wb_op(1'b0, 26'd0, 32'h0, 4'hF, 1'b0, 1'b0, a, e, d);
    chk("t6_read_cmdq_err", 32'(e), 32'd1);
    wb_op(1'b1, 26'd2, 32'h0, 4'hF, 1'b0, 1'b0, a, e, d);
    chk("t6_write_status_err", 32'(e), 32'd1);
    wb_op(1'b0, 26'h100002, 32'h0, 4'hF, 1'b0, 1'b0, a, e, d);
    chk("t6_upper_addr_err", 32'(e), 32'd1);
    rsp_data = 8'h5A;
    wb_op(1'b1, 26'd0, 32'h055, 4'h3, 1'b0, 1'b1, a, e, d);
    chk("t6_pre_reset_valid", 32'(o_cmd_valid), 32'd1);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; addr = 26'd2;
    #2 rst = 1;
    #1;
    chk("t6_rst_ack", 32'(o_ack), 32'd0);
    chk("t6_rst_cmd_valid", 32'(o_cmd_valid), 32'd0);
    chk("t6_rst_cmd_data", 32'(o_cmd_data), 32'd0);
    @(posedge clk); #2;
    chk("t6_rst_no_ack", 32'(o_ack), 32'd0);
    @(negedge clk); cyc = 0; stb = 0; rst = 0;
    @(posedge clk); #2;
    chk("t6_after_rst_no_ack", 32'(o_ack), 32'd0);
    wb_op(1'b0, 26'd2, 32'd0, 4'hF, 1'b0, 1'b0, a, e, d);
    chk("t6_status_after_rst", d, 32'h0002_0000);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
